serial_divider: RTL and testbench

Multi-cycle unsigned restoring divider for the 8-bit datapath, producing quotient and remainder in WIDTH iterations. It performs the inverse of the shift-and-add multiplier and shares the ALU operand buses. The control unit stalls on BUSY. Each iteration does one trial subtraction through a ripple borrow-subtractor built from one-bit adder cells.

---
 rtl/serial_divider_pkg.sv | 17 +
 rtl/serial_divider_borrow_subtractor.sv | 25 ++
 rtl/serial_divider.sv | 140 ++++++++++++++
 tb/tb_serial_divider.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_divider_pkg.sv
// rtl/serial_divider_pkg.sv - shared state encodings and sizing for the serial divider
package serial_divider_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FIN  = 2'b10
  } state_e;

  // Iteration counter must hold the value WIDTH, hence one bit above clog2.
  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/serial_divider_borrow_subtractor.sv
// rtl/serial_divider_borrow_subtractor.sv - ripple borrow subtractor from one-bit adder cells
module borrow_subtractor #(
  parameter int N = 9
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] diff,
  output logic         borrow
);

  // a - b computed as a + ~b + 1; a missing final carry means a borrow.
  logic [N:0] carry;

  assign carry[0] = 1'b1;

  for (genvar i = 0; i < N; i++) begin : g_cell
    logic b_n;
    assign b_n          = ~b[i];
    assign diff[i]      = a[i] ^ b_n ^ carry[i];
    assign carry[i + 1] = (a[i] & b_n) | (carry[i] & (a[i] ^ b_n));
  end

  assign borrow = ~carry[N];

endmodule

// File: rtl/serial_divider.sv
// rtl/serial_divider.sv - multi-cycle unsigned restoring divider
module serial_divider
  import serial_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic [WIDTH-1:0] DIVIDEND,
  input  logic [WIDTH-1:0] DIVISOR,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] QUOTIENT,
  output logic [WIDTH-1:0] REMAINDER,
  output logic             DIV_BY_ZERO
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] divisor_q, divisor_d;
  logic [WIDTH-1:0] q_work_q, q_work_d;
  logic [WIDTH:0]   r_work_q, r_work_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH:0]   r_shifted;
  logic [WIDTH-1:0] q_shifted;
  logic [WIDTH:0]   trial_diff;
  logic             trial_borrow;

  // The quotient MSB shifts into the remainder LSB as the pair moves left.
  assign r_shifted = (r_work_q << 1) | {{WIDTH{1'b0}}, q_work_q[WIDTH-1]};
  assign q_shifted = q_work_q << 1;

  borrow_subtractor #(
    .N (WIDTH + 1)
  ) u_sub (
    .a      (r_shifted),
    .b      ({1'b0, divisor_q}),
    .diff   (trial_diff),
    .borrow (trial_borrow)
  );

  // Next-state, iteration and result-register logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    divisor_d   = divisor_q;
    q_work_d    = q_work_q;
    r_work_d    = r_work_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;

    case (state_q)
      ST_IDLE, ST_FIN: begin
        if (START) begin
          if (DIVISOR != '0) begin
            state_d   = ST_RUN;
            divisor_d = DIVISOR;
            q_work_d  = DIVIDEND;
            r_work_d  = '0;
            cnt_d     = '0;
            dbz_d     = 1'b0;
          end else begin
            // Divide by zero completes immediately with a saturated quotient.
            state_d     = ST_FIN;
            quotient_d  = '1;
            remainder_d = DIVIDEND;
            dbz_d       = 1'b1;
          end
        end else if (state_q == ST_FIN) begin
          state_d = ST_IDLE;
        end
      end

      ST_RUN: begin
        if (trial_borrow) begin
          r_work_d = r_shifted;
          q_work_d = q_shifted;
        end else begin
          r_work_d = trial_diff;
          q_work_d = q_shifted | {{(WIDTH-1){1'b0}}, 1'b1};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_ITER) begin
          state_d     = ST_FIN;
          quotient_d  = q_work_d;
          remainder_d = r_work_d[WIDTH-1:0];
        end
      end

      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_FIN);
  end

  // State and output registers; reset discards any in-flight division.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      divisor_q   <= '0;
      q_work_q    <= '0;
      r_work_q    <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      divisor_q   <= divisor_d;
      q_work_q    <= q_work_d;
      r_work_q    <= r_work_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign BUSY        = busy_q;
  assign DONE        = done_q;
  assign QUOTIENT    = quotient_q;
  assign REMAINDER   = remainder_q;
  assign DIV_BY_ZERO = dbz_q;

endmodule

// File: tb/tb_serial_divider.sv
// tb/tb_serial_divider.sv - scoreboard bench for serial_divider
module tb_serial_divider;

  logic       CLK;
  logic       RESET;
  logic       START;
  logic [7:0] DIVIDEND;
  logic [7:0] DIVISOR;
  logic       BUSY;
  logic       DONE;
  logic [7:0] QUOTIENT;
  logic [7:0] REMAINDER;
  logic       DIV_BY_ZERO;

  serial_divider #(.WIDTH(8)) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .START       (START),
    .DIVIDEND    (DIVIDEND),
    .DIVISOR     (DIVISOR),
    .BUSY        (BUSY),
    .DONE        (DONE),
    .QUOTIENT    (QUOTIENT),
    .REMAINDER   (REMAINDER),
    .DIV_BY_ZERO (DIV_BY_ZERO)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    logic       z;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   tests    = 0;
  int   fails    = 0;
  int   done_cnt = 0;
  int   issued   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // Monitor: every DONE pulse is matched against the oldest expected result.
  always @(negedge CLK) begin
    if (RESET && DONE) begin
      done_cnt++;
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("quotient", {24'd0, QUOTIENT}, {24'd0, mon_e.q});
        check("remainder", {24'd0, REMAINDER}, {24'd0, mon_e.r});
        check("div_by_zero", {31'd0, DIV_BY_ZERO}, {31'd0, mon_e.z});
        check("busy_in_fin", {31'd0, BUSY}, 32'd0);
      end
    end
  end

  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] q, input logic [7:0] r, input logic z,
                        input int exp_busy, input int exp_lat);
    int lat;
    int busy_cycles;
    sb.push_back('{q: q, r: r, z: z});
    issued++;
    @(negedge CLK);
    START    = 1'b1;
    DIVIDEND = a;
    DIVISOR  = b;
    @(posedge CLK);
    #1;
    START       = 1'b0;
    lat         = 1;
    busy_cycles = 0;
    while (!DONE && lat < 40) begin
      if (BUSY) busy_cycles++;
      @(posedge CLK);
      #1;
      lat++;
    end
    check("done_latency", lat, exp_lat);
    check("busy_cycles", busy_cycles, exp_busy);
    @(posedge CLK);
    #1;
    check("done_single_pulse", {31'd0, DONE}, 32'd0);
  endtask

  initial begin
    int lat;
    logic [7:0] a;
    logic [7:0] b;

    RESET    = 1'b0;
    START    = 1'b0;
    DIVIDEND = 8'd0;
    DIVISOR  = 8'd0;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_busy", {31'd0, BUSY}, 32'd0);
    check("rst_done", {31'd0, DONE}, 32'd0);
    check("rst_quotient", {24'd0, QUOTIENT}, 32'd0);
    check("rst_remainder", {24'd0, REMAINDER}, 32'd0);
    check("rst_dbz", {31'd0, DIV_BY_ZERO}, 32'd0);
    @(negedge CLK);
    RESET = 1'b1;

    run_op(8'd100, 8'd7,   8'd14,  8'd2, 1'b0, 8, 9);
    run_op(8'd255, 8'd1,   8'd255, 8'd0, 1'b0, 8, 9);
    run_op(8'd3,   8'd200, 8'd0,   8'd3, 1'b0, 8, 9);
    run_op(8'd5,   8'd0,   8'hFF,  8'd5, 1'b1, 0, 1);

    // Reset mid-RUN: outputs clear immediately and the result is dropped.
    @(negedge CLK);
    START    = 1'b1;
    DIVIDEND = 8'd200;
    DIVISOR  = 8'd16;
    @(posedge CLK);
    #1;
    START = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check("mid_run_busy", {31'd0, BUSY}, 32'd1);
    RESET = 1'b0;
    #1;
    check("async_rst_busy", {31'd0, BUSY}, 32'd0);
    check("async_rst_done", {31'd0, DONE}, 32'd0);
    check("async_rst_quotient", {24'd0, QUOTIENT}, 32'd0);
    check("async_rst_remainder", {24'd0, REMAINDER}, 32'd0);
    check("async_rst_dbz", {31'd0, DIV_BY_ZERO}, 32'd0);
    @(negedge CLK);
    RESET = 1'b1;
    run_op(8'd200, 8'd16, 8'd12, 8'd8, 1'b0, 8, 9);

    // START held high: operand change during RUN is ignored, FIN re-accepts.
    sb.push_back('{q: 8'd16, r: 8'd2, z: 1'b0});
    sb.push_back('{q: 8'd1,  r: 8'd0, z: 1'b0});
    issued += 2;
    @(negedge CLK);
    START    = 1'b1;
    DIVIDEND = 8'd50;
    DIVISOR  = 8'd3;
    @(posedge CLK);
    #1;
    DIVIDEND = 8'd77;
    DIVISOR  = 8'd77;
    lat = 1;
    while (!DONE && lat < 40) begin
      @(posedge CLK);
      #1;
      lat++;
    end
    check("b2b_first_latency", lat, 9);
    @(posedge CLK);
    #1;
    check("b2b_accept_busy", {31'd0, BUSY}, 32'd1);
    check("b2b_accept_done", {31'd0, DONE}, 32'd0);
    START = 1'b0;
    lat = 1;
    while (!DONE && lat < 40) begin
      @(posedge CLK);
      #1;
      lat++;
    end
    check("b2b_second_latency", lat, 9);
    @(posedge CLK);
    #1;
    check("b2b_single_pulse", {31'd0, DONE}, 32'd0);

    // Boundary vectors.
    run_op(8'd0,   8'd1,   8'd0,   8'd0,   1'b0, 8, 9);
    run_op(8'd255, 8'd255, 8'd1,   8'd0,   1'b0, 8, 9);
    run_op(8'd254, 8'd255, 8'd0,   8'd254, 1'b0, 8, 9);
    run_op(8'd255, 8'd2,   8'd127, 8'd1,   1'b0, 8, 9);
    run_op(8'd128, 8'd128, 8'd1,   8'd0,   1'b0, 8, 9);
    run_op(8'd0,   8'd0,   8'hFF,  8'd0,   1'b1, 0, 1);

    // Sampled sweep against the arithmetic reference.
    for (int i = 0; i < 150; i++) begin
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(1, 255));
      run_op(a, b, a / b, a % b, 1'b0, 8, 9);
    end

    repeat (3) @(posedge CLK);
    #1;
    check("scoreboard_empty", sb.size(), 0);
    check("done_per_start", done_cnt, issued);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
